prime_bus_host: RTL



---
 rtl/prime_bus_host.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/prime_bus_host.sv
// prime_bus_host
// Host-side bus initiator for the GPIO-emulator CPU bus. It accepts an
// "N-th prime" request and runs a fixed sequence of bus cycles:
//   1. write N to the argument register
//   2. poll the status register until bit 0 reads 0
//   3. read the result register
// It then returns the prime on the response port.
// Every bus cycle has three parts: SETUP, then STROBE_CYCLES of strobe, then
// HOLD. Read data is taken at the end of HOLD.
// Ports:
//   clk, n_reset                     clock, asynchronous active-low reset
//   req_valid/req_ready/req_n        request channel (N, 1-based)
//   rsp_valid/rsp_ready/rsp_prime    response channel
//   rsp_error, rsp_timeout           N==0 reject, MAX_POLLS exhausted
//   saddress/swr/srd/sdata_out       bus outputs
//   sdata_in                         bus read data
// The bus and handshake outputs are decoded straight from the state
// registers. An asynchronous reset therefore drops a strobe at once.
module prime_bus_host #(
  parameter logic [15:0] ADDR_ARG      = 16'h288,
  parameter logic [15:0] ADDR_RES      = 16'h298,
  parameter logic [15:0] ADDR_STAT     = 16'h2A0,
  parameter int          STROBE_CYCLES = 2,
  parameter int          POLL_GAP      = 4,
  parameter int          MAX_POLLS     = 1023
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_n,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_prime,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [15:0] saddress,
  output logic        swr,
  output logic        srd,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);

  localparam int CW = 16;
  localparam int PW = ($clog2(MAX_POLLS + 1) > 10) ? $clog2(MAX_POLLS + 1) : 10;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, RESP} state_t;
  typedef enum logic [1:0] {WR_ARG, RD_STAT, RD_RES} phase_t;

  // With no poll gap, the cycle after HOLD goes straight to the next SETUP.
  localparam state_t AFTER_HOLD = (POLL_GAP == 0) ? SETUP : GAP;

  state_t        state, state_nx;
  phase_t        phase, phase_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [PW-1:0] poll_cnt, poll_nx;
  logic [9:0]    n_q, n_nx;
  logic [31:0]   prime_q, prime_nx;
  logic          err_q, err_nx, to_q, to_nx;
  logic [15:0]   cur_addr;
  logic          bus_act;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state    <= IDLE;
      phase    <= WR_ARG;
      cnt      <= '0;
      poll_cnt <= '0;
      n_q      <= '0;
      prime_q  <= '0;
      err_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      cnt      <= cnt_nx;
      poll_cnt <= poll_nx;
      n_q      <= n_nx;
      prime_q  <= prime_nx;
      err_q    <= err_nx;
      to_q     <= to_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase;
    cnt_nx   = cnt;
    poll_nx  = poll_cnt;
    n_nx     = n_q;
    prime_nx = prime_q;
    err_nx   = err_q;
    to_nx    = to_q;
    case (state)
      IDLE: if (req_valid) begin
        if (req_n == 10'd0) begin
          state_nx = RESP;
          err_nx   = 1'b1;
          to_nx    = 1'b0;
          prime_nx = '0;
        end else begin
          n_nx     = req_n;
          phase_nx = WR_ARG;
          poll_nx  = '0;
          state_nx = SETUP;
        end
      end
      SETUP: begin
        cnt_nx   = '0;
        state_nx = STROBE;
      end
      STROBE: begin
        if (cnt == CW'(STROBE_CYCLES - 1)) state_nx = HOLD;
        else                               cnt_nx   = cnt + CW'(1);
      end
      HOLD: begin
        cnt_nx = '0;
        case (phase)
          WR_ARG: begin
            phase_nx = RD_STAT;
            state_nx = AFTER_HOLD;
          end
          RD_STAT: begin
            poll_nx = poll_cnt + PW'(1);
            // A "done" status takes priority over an expiring poll budget.
            if (!sdata_in[0]) begin
              phase_nx = RD_RES;
              state_nx = SETUP;
            end else if (poll_cnt + PW'(1) == PW'(MAX_POLLS)) begin
              state_nx = RESP;
              to_nx    = 1'b1;
              prime_nx = '0;
            end else begin
              state_nx = AFTER_HOLD;
            end
          end
          default: begin
            state_nx = RESP;
            prime_nx = sdata_in;
          end
        endcase
      end
      GAP: begin
        if (cnt == CW'(POLL_GAP - 1)) state_nx = SETUP;
        else                          cnt_nx   = cnt + CW'(1);
      end
      RESP: if (rsp_ready) begin
        state_nx = IDLE;
        err_nx   = 1'b0;
        to_nx    = 1'b0;
        prime_nx = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    case (phase)
      RD_STAT: cur_addr = ADDR_STAT;
      RD_RES:  cur_addr = ADDR_RES;
      default: cur_addr = ADDR_ARG;
    endcase
  end

  assign bus_act     = (state == SETUP) || (state == STROBE) || (state == HOLD);
  assign saddress    = bus_act ? cur_addr : 16'h0;
  assign sdata_out   = (bus_act && phase == WR_ARG) ? {22'b0, n_q} : 32'h0;
  assign swr         = (state == STROBE) && (phase == WR_ARG);
  assign srd         = (state == STROBE) && (phase != WR_ARG);
  assign req_ready   = (state == IDLE);
  assign rsp_valid   = (state == RESP);
  assign rsp_prime   = prime_q;
  assign rsp_error   = err_q;
  assign rsp_timeout = to_q;

endmodule
